// File: rtl/aes128_iter_cipher_pkg.sv
// Shared AES-128 definitions: S-box, xtime, round-key slicing and FSM encodings.
package aes128_iter_cipher_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned RK_W   = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] hi;
    hi = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[hi -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round key i sits at the top of the bus, rk0 first.
  function automatic logic [RK_W-1:0] rk(input logic [2047:0] bus, input logic [3:0] i);
    logic [10:0] hi;
    hi = 11'd2047 - {i, 7'b0};
    return bus[hi -: RK_W];
  endfunction

endpackage

// File: rtl/aes128_iter_cipher_if.sv
// Plaintext-in / ciphertext-out handshake bundle for aes128_iter_cipher.
interface aes128_iter_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] Plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] Ciphertext;
  logic         busy;

  modport master (
    output in_valid, Plaintext, out_ready,
    input  in_ready, out_valid, Ciphertext, busy
  );

  modport slave (
    input  in_valid, Plaintext, out_ready,
    output in_ready, out_valid, Ciphertext, busy
  );
endinterface

// File: rtl/aes128_iter_cipher_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when final), AddRoundKey.
module aes128_iter_cipher_round
  import aes128_iter_cipher_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] next_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_i[127-8*i -: 8]);
  end

  // Byte index is 4*column + row; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign next_o[127-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ rk_i[127-8*i -: 8];
  end

endmodule

// File: rtl/aes128_iter_cipher.sv
// Iterative AES-128 encryptor: AddRoundKey at acceptance, then one round per clock.
// Define AES_KEY_LATCH_EN to capture round keys at acceptance instead of reading live Keyin.
module aes128_iter_cipher
  import aes128_iter_cipher_pkg::*;
#(
  parameter int unsigned NR     = AES_NR,
  parameter int unsigned KBUS_W = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KBUS_W-1:0] Keyin,
  aes128_iter_cipher_if.slave bus
);

  localparam logic [3:0] LastRnd = 4'(NR);

  state_e       st_q;
  logic [3:0]   rcnt_q;
  logic [127:0] sreg_q;
  logic [127:0] ct_q;
  logic         out_valid_q;
  logic         busy_q;
  logic [127:0] round_out;
  logic [KBUS_W-1:0] kbus;
  logic         accept;

  assign accept = (st_q == StIdle) && bus.in_valid;

`ifdef AES_KEY_LATCH_EN
  logic [1407:0] key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (accept) begin
      key_q <= Keyin[KBUS_W-1 -: 1408];
    end
  end

  assign kbus = {key_q, {(KBUS_W-1408){1'b0}}};
`else
  assign kbus = Keyin;
`endif

  aes128_iter_cipher_round u_round (
    .state_i (sreg_q),
    .rk_i    (rk(kbus, rcnt_q)),
    .final_i (rcnt_q == LastRnd),
    .next_o  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      rcnt_q      <= '0;
      sreg_q      <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (bus.in_valid) begin
            sreg_q <= bus.Plaintext ^ rk(Keyin, 4'd0);
            rcnt_q <= 4'd1;
            busy_q <= 1'b1;
            st_q   <= StRound;
          end
        end
        StRound: begin
          sreg_q <= round_out;
          if (rcnt_q == LastRnd) begin
            ct_q        <= round_out;
            rcnt_q      <= '0;
            out_valid_q <= 1'b1;
            st_q        <= StDone;
          end else begin
            rcnt_q <= rcnt_q + 4'd1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            st_q        <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign bus.in_ready   = rst_n && (st_q == StIdle);
  assign bus.out_valid  = out_valid_q;
  assign bus.Ciphertext = ct_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes128_iter_cipher.sv
// Directed FIPS-197 vector bench for aes128_iter_cipher.
module tb_aes128_iter_cipher;
  import aes128_iter_cipher_pkg::*;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic          clk;
  logic          rst_n;
  logic [2047:0] Keyin;
  int            n_tests;
  int            n_fail;

  aes128_iter_cipher_if bus ();

  aes128_iter_cipher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Keyin (Keyin),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream key expansion, producing the 11-round-key bus.
  function automatic logic [2047:0] expand(input logic [127:0] key);
    logic [1407:0] acc;
    logic [31:0]   w0, w1, w2, w3, t;
    logic [7:0]    rc;
    acc = {1280'b0, key};
    {w0, w1, w2, w3} = key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      rc = xtime(rc);
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      acc = {acc[1279:0], w0, w1, w2, w3};
    end
    return {acc, 640'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one block (in_ready assumed high) and waits, bounded, for out_valid.
  task automatic send_and_wait(input logic [127:0] pt, output logic [127:0] ct, output int lat);
    bus.Plaintext = pt;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    ct = bus.Ciphertext;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    n_tests++;
    if (bus.Ciphertext !== 128'h0) begin
      n_fail++; $display("FAIL reset_ct: got %h want 0", bus.Ciphertext);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_fips_c1();
    logic [127:0] ct;
    int lat;
    Keyin = expand(KEY_C1);
    bus.out_ready = 1'b1;
    send_and_wait(PT_C1, ct, lat);
    n_tests++;
    if (lat !== 10) begin
      n_fail++; $display("FAIL c1_latency: got %0d want 10", lat);
    end
    n_tests++;
    if (ct !== CT_C1) begin
      n_fail++; $display("FAIL c1_ct: got %h want %h", ct, CT_C1);
    end
    n_tests++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL c1_done_flags: busy=%b in_ready=%b want 1 0", bus.busy, bus.in_ready);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL c1_handshake: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    n_tests++;
    if (bus.Ciphertext !== CT_C1) begin
      n_fail++; $display("FAIL c1_ct_hold: got %h want %h", bus.Ciphertext, CT_C1);
    end
  endtask

  task automatic test_fips_b();
    logic [127:0] ct;
    int lat;
    Keyin = expand(KEY_B);
    bus.out_ready = 1'b1;
    send_and_wait(PT_B, ct, lat);
    n_tests++;
    if (ct !== CT_B || lat !== 10) begin
      n_fail++; $display("FAIL b_ct: got %h lat %0d want %h lat 10", ct, lat, CT_B);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] ct;
    int lat;
    Keyin = expand(KEY_C1);
    bus.out_ready = 1'b0;
    send_and_wait(PT_C1, ct, lat);
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.Ciphertext !== CT_C1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b ct=%h want 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.Ciphertext, CT_C1);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_busy_reject();
    int lat;
    Keyin = expand(KEY_C1);
    bus.out_ready = 1'b1;
    bus.Plaintext = PT_C1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_flags: in_ready=%b busy=%b want 0 1", bus.in_ready, bus.busy);
    end
    bus.Plaintext = PT_B;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 3;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    n_tests++;
    if (bus.Ciphertext !== CT_C1 || lat !== 10) begin
      n_fail++; $display("FAIL busy_ct: got %h lat %0d want %h lat 10", bus.Ciphertext, lat, CT_C1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct0, ct1;
    logic rdy;
    int acc, got, t0, t1;
    acc = 0; got = 0; t0 = -1; t1 = -1;
    ct0 = '0; ct1 = '0;
    Keyin = expand(KEY_C1);
    bus.out_ready = 1'b1;
    bus.Plaintext = PT_C1;
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 40 && got < 2; t++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) begin
        if (acc == 0) begin
          t0 = t;
          bus.Plaintext = PT_B;
        end else begin
          t1 = t;
          bus.in_valid = 1'b0;
        end
        acc++;
      end
      if (bus.out_valid) begin
        if (got == 0) begin
          ct0 = bus.Ciphertext;
          Keyin = expand(KEY_B);
        end else begin
          ct1 = bus.Ciphertext;
        end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (acc !== 2 || t1 - t0 !== 12) begin
      n_fail++; $display("FAIL b2b_interval: accepts=%0d gap=%0d want 2 12", acc, t1 - t0);
    end
    n_tests++;
    if (ct0 !== CT_C1) begin
      n_fail++; $display("FAIL b2b_ct0: got %h want %h", ct0, CT_C1);
    end
    n_tests++;
    if (ct1 !== CT_B || got !== 2) begin
      n_fail++; $display("FAIL b2b_ct1: got %h (results %0d) want %h", ct1, got, CT_B);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct;
    int lat;
    Keyin = expand(KEY_C1);
    bus.out_ready = 1'b1;
    bus.Plaintext = PT_C1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.Ciphertext !== 128'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: out_valid=%b busy=%b ct=%h want 0 0 0",
               bus.out_valid, bus.busy, bus.Ciphertext);
    end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_idle: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    Keyin = expand(KEY_B);
    send_and_wait(PT_B, ct, lat);
    n_tests++;
    if (ct !== CT_B || lat !== 10) begin
      n_fail++; $display("FAIL midrst_next: got %h lat %0d want %h lat 10", ct, lat, CT_B);
    end
    tick();
  endtask

`ifdef AES_KEY_LATCH_EN
  task automatic test_key_latch();
    int lat;
    Keyin = expand(KEY_C1);
    bus.out_ready = 1'b1;
    bus.Plaintext = PT_C1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    Keyin = {$urandom, $urandom, $urandom, $urandom, 1920'h5a5a};
    lat = 1;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    n_tests++;
    if (bus.Ciphertext !== CT_C1 || lat !== 10) begin
      n_fail++; $display("FAIL latch_ct: got %h lat %0d want %h lat 10", bus.Ciphertext, lat, CT_C1);
    end
    tick();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Keyin         = '0;
    bus.in_valid  = 1'b0;
    bus.Plaintext = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_KEY_LATCH_EN
    test_key_latch();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
